hazard_ctrl_unit: RTL and testbench

Parametrised pipeline control and hazard unit for the 151LA RISC-V core. It decodes the instruction in the execute (X) stage and tracks destination registers of the FWD_STAGES younger-retiring stages (M, W, ...). It produces multi-source forwarding selects, load-use stalls, taken-branch/jump redirects with a registered wrong-path kill, and a post-reset PC hold. It extends the single-level combinational X/M decode with stage tracking, stall/kill sequencing and configurable forwarding depth.

---
 rtl/hazard_ctrl_pkg.sv | 54 +++++
 rtl/hazard_ctrl_unit_fwd_match.sv | 33 +++
 rtl/hazard_ctrl_unit.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the X-stage control / hazard unit.
// Holds the RV32I opcode and funct3 encodings the unit decodes, the canonical
// NOP word, the PC_sel and forwarding-select encodings, the per-stage tracker
// record and small opcode-classification helpers.
package hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [1:0] PCSEL_PC4  = 2'd0;
  localparam logic [1:0] PCSEL_ALU  = 2'd1;
  localparam logic [1:0] PCSEL_RST  = 2'd2;
  localparam logic [1:0] PCSEL_HOLD = 2'd3;

  // Forwarding select: 0 = register file, k = tracked stage k (1 = M, 2 = W).
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
  } trk_t;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_RTYPE || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    return !(opc == OPC_BRANCH || opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_match.sv
// Priority match of one source register against the tracked later stages.
// Ports:
//   rs    in  5           source register index
//   use_rs in 1           instruction actually reads this source
//   cand  in  FWD_STAGES  per stage: entry valid and writes rd
//   rd    in  FWD_STAGES x 5  per stage destination register
//   sel   out FW          0 = register file, k = youngest matching stage k
module hazard_fwd_match
  import hazard_ctrl_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int FW         = $clog2(FWD_STAGES + 1)
) (
  input  logic [4:0]                  rs,
  input  logic                        use_rs,
  input  logic [FWD_STAGES-1:0]       cand,
  input  logic [FWD_STAGES-1:0][4:0]  rd,
  output logic [FW-1:0]               sel
);

  // Scan oldest to youngest so the youngest (smallest k) match wins.
  always_comb begin
    sel = FW'(FWD_REGFILE);
    if (use_rs && rs != 5'd0) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (cand[k] && rd[k] == rs) begin
          sel = FW'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// X-stage decode, forwarding, load-use stall, redirect/kill and reset hold.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr_X           instruction currently in X
//   BrEq, BrLT        branch comparator results
//   fw_RS1, fw_RS2    operand source selects (0 regfile, k = stage k)
//   BrUn              unsigned compare for BLTU/BGEU
//   RegWEn, MemRW     X writes rd / X is a store (only when X is live)
//   PC_sel            0 PC+4, 1 ALU target, 2 reset vector, 3 hold
//   stall             load-use bubble
//   NOP               X is killed (wrong path or reset hold)
module hazard_ctrl_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FWD_STAGES = 2,
  parameter int RST_HOLD   = 2,
  parameter int FW         = $clog2(FWD_STAGES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr_X,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic [FW-1:0]   fw_RS1,
  output logic [FW-1:0]   fw_RS2,
  output logic            BrUn,
  output logic            RegWEn,
  output logic            MemRW,
  output logic [1:0]      PC_sel,
  output logic            stall,
  output logic            NOP
);

  localparam int HW = $clog2(RST_HOLD + 1);

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       use1, use2, is_nop_word, hold, vx, taken, ld_hit;
  logic [HW-1:0] hold_cnt_reg;
  logic       kill_reg;
  trk_t       stage1_next;
  trk_t [FWD_STAGES-1:0]      trk_vec;
  logic [FWD_STAGES-1:0]      cand_vec;
  logic [FWD_STAGES-1:0][4:0] rd_vec;
  logic       unused_last_load;

  assign opc         = instr_X[6:0];
  assign rd          = instr_X[11:7];
  assign funct3      = instr_X[14:12];
  assign rs1         = instr_X[19:15];
  assign rs2         = instr_X[24:20];
  assign use1        = uses_rs1(opc);
  assign use2        = uses_rs2(opc);
  assign is_nop_word = (instr_X == XLEN'(INSTR_NOP));

  assign hold = (hold_cnt_reg != '0);
  assign NOP  = hold | kill_reg;

  // A load one stage ahead cannot forward in time; hold X for one cycle.
  assign ld_hit = trk_vec[0].valid & trk_vec[0].is_load &
                  ((use1 & (rs1 != 5'd0) & (trk_vec[0].rd == rs1)) |
                   (use2 & (rs2 != 5'd0) & (trk_vec[0].rd == rs2)));
  assign stall  = ~NOP & ld_hit;

  assign vx     = ~NOP & ~stall & ~is_nop_word;
  assign RegWEn = vx & writes_rd(opc);
  assign MemRW  = vx & (opc == OPC_STORE);
  assign BrUn   = (opc == OPC_BRANCH) & (funct3 == F3_BLTU || funct3 == F3_BGEU);

  always_comb begin
    taken = 1'b0;
    case (opc)
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:           taken = BrEq;
          F3_BNE:           taken = ~BrEq;
          F3_BLT, F3_BLTU:  taken = BrLT;
          F3_BGE, F3_BGEU:  taken = ~BrLT;
          default:          taken = 1'b0;
        endcase
      end
      OPC_JAL, OPC_JALR: taken = 1'b1;
      default:           taken = 1'b0;
    endcase
  end

  // A killed slot never redirects, which also blocks back-to-back redirects.
  always_comb begin
    if (hold)          PC_sel = PCSEL_RST;
    else if (kill_reg) PC_sel = PCSEL_PC4;
    else if (stall)    PC_sel = PCSEL_HOLD;
    else if (taken)    PC_sel = PCSEL_ALU;
    else               PC_sel = PCSEL_PC4;
  end

  always_comb begin
    stage1_next         = '0;
    stage1_next.valid   = vx;
    stage1_next.rd      = rd;
    stage1_next.wen     = writes_rd(opc);
    stage1_next.is_load = (opc == OPC_LOAD);
  end

  // Stage tracker: stage 1 takes X (a bubble when stalled/killed), every
  // older stage takes its younger neighbour unconditionally.
  for (genvar gi = 0; gi < FWD_STAGES; gi++) begin : g_stage
    trk_t ent_reg;
    trk_t ent_next;
    if (gi == 0) begin : g_head
      assign ent_next = stage1_next;
    end else begin : g_tail
      assign ent_next = trk_vec[gi-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ent_reg <= '0;
      else        ent_reg <= ent_next;
    end
    assign trk_vec[gi]  = ent_reg;
    assign cand_vec[gi] = ent_reg.valid & ent_reg.wen;
    assign rd_vec[gi]   = ent_reg.rd;
  end

  // The oldest stage's load flag has no consumer.
  assign unused_last_load = trk_vec[FWD_STAGES-1].is_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= HW'(RST_HOLD);
      kill_reg     <= 1'b0;
    end else begin
      if (hold) hold_cnt_reg <= hold_cnt_reg - 1'b1;
      kill_reg <= (PC_sel == PCSEL_ALU);
    end
  end

  hazard_fwd_match #(.FWD_STAGES(FWD_STAGES), .FW(FW)) u_fwd_rs1 (
    .rs     (rs1),
    .use_rs (use1),
    .cand   (cand_vec),
    .rd     (rd_vec),
    .sel    (fw_RS1)
  );

  hazard_fwd_match #(.FWD_STAGES(FWD_STAGES), .FW(FW)) u_fwd_rs2 (
    .rs     (rs2),
    .use_rs (use2),
    .cand   (cand_vec),
    .rd     (rd_vec),
    .sel    (fw_RS2)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized plus directed bench for hazard_ctrl_unit. Two instances share
// the stimulus: dut_a with two tracked stages, dut_b with one. A behavioural
// model (instruction history per instance) predicts every output each cycle.
module tb_hazard_ctrl_unit;

  localparam int RST_HOLD = 2;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011, OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011, OP_I     = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_X;
  logic        BrEq, BrLT;

  logic [1:0] fw1_a, fw2_a, pcsel_a;
  logic       brun_a, regwen_a, memrw_a, stall_a, nop_a;
  logic [0:0] fw1_b, fw2_b;
  logic [1:0] pcsel_b;
  logic       brun_b, regwen_b, memrw_b, stall_b, nop_b;

  hazard_ctrl_unit #(.XLEN(32), .FWD_STAGES(2), .RST_HOLD(RST_HOLD)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr_X(instr_X), .BrEq(BrEq), .BrLT(BrLT),
    .fw_RS1(fw1_a), .fw_RS2(fw2_a), .BrUn(brun_a), .RegWEn(regwen_a),
    .MemRW(memrw_a), .PC_sel(pcsel_a), .stall(stall_a), .NOP(nop_a)
  );

  hazard_ctrl_unit #(.XLEN(32), .FWD_STAGES(1), .RST_HOLD(RST_HOLD)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_X(instr_X), .BrEq(BrEq), .BrLT(BrLT),
    .fw_RS1(fw1_b), .fw_RS2(fw2_b), .BrUn(brun_b), .RegWEn(regwen_b),
    .MemRW(memrw_b), .PC_sel(pcsel_b), .stall(stall_b), .NOP(nop_b)
  );

  logic [1:0] o_fw1 [2];
  logic [1:0] o_fw2 [2];
  logic [1:0] o_pcsel [2];
  logic       o_stall [2], o_nop [2], o_regwen [2], o_memrw [2], o_brun [2];

  assign o_fw1[0] = fw1_a;            assign o_fw1[1] = {1'b0, fw1_b};
  assign o_fw2[0] = fw2_a;            assign o_fw2[1] = {1'b0, fw2_b};
  assign o_pcsel[0] = pcsel_a;        assign o_pcsel[1] = pcsel_b;
  assign o_stall[0] = stall_a;        assign o_stall[1] = stall_b;
  assign o_nop[0] = nop_a;            assign o_nop[1] = nop_b;
  assign o_regwen[0] = regwen_a;      assign o_regwen[1] = regwen_b;
  assign o_memrw[0] = memrw_a;        assign o_memrw[1] = memrw_b;
  assign o_brun[0] = brun_a;          assign o_brun[1] = brun_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // History slot k holds what the X instruction of k cycles ago left behind.
  int   depth [2] = '{2, 1};
  bit   h_valid [2][4];
  bit   h_wen   [2][4];
  bit   h_load  [2][4];
  logic [4:0] h_rd [2][4];
  int   hold_left [2];
  bit   kill_q [2];

  int   e_fw1 [2], e_fw2 [2], e_pcsel [2];
  bit   e_stall [2], e_nop [2], e_regwen [2], e_memrw [2], e_brun [2], e_vx [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        h_valid[i][k] = 0; h_wen[i][k] = 0; h_load[i][k] = 0; h_rd[i][k] = '0;
      end
      hold_left[i] = RST_HOLD;
      kill_q[i]    = 0;
    end
  endtask

  function automatic int find_src(input int i, input logic [4:0] rs, input bit use_rs);
    if (!use_rs || rs == 5'd0) return 0;
    for (int k = 1; k <= depth[i]; k++)
      if (h_valid[i][k] && h_wen[i][k] && h_rd[i][k] == rs) return k;
    return 0;
  endfunction

  task automatic model_eval();
    logic [6:0] op;
    logic [4:0] rs1, rs2;
    logic [2:0] f3;
    bit use1, use2, taken, hold, nop, stl, hit_ld;
    op  = instr_X[6:0];
    f3  = instr_X[14:12];
    rs1 = instr_X[19:15];
    rs2 = instr_X[24:20];
    use1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    use2 = (op == OP_R || op == OP_ST || op == OP_BR);
    taken = 0;
    if (op == OP_JAL || op == OP_JALR) taken = 1;
    else if (op == OP_BR) begin
      if (f3 == 3'd0)                    taken = BrEq;
      else if (f3 == 3'd1)               taken = !BrEq;
      else if (f3 == 3'd4 || f3 == 3'd6) taken = BrLT;
      else if (f3 == 3'd5 || f3 == 3'd7) taken = !BrLT;
    end
    for (int i = 0; i < 2; i++) begin
      hold = (hold_left[i] > 0);
      nop  = hold || kill_q[i];
      hit_ld = h_valid[i][1] && h_load[i][1] &&
               ((use1 && rs1 != 0 && h_rd[i][1] == rs1) ||
                (use2 && rs2 != 0 && h_rd[i][1] == rs2));
      stl = !nop && hit_ld;
      e_fw1[i]   = find_src(i, rs1, use1);
      e_fw2[i]   = find_src(i, rs2, use2);
      e_stall[i] = stl;
      e_nop[i]   = nop;
      if (hold)           e_pcsel[i] = 2;
      else if (kill_q[i]) e_pcsel[i] = 0;
      else if (stl)       e_pcsel[i] = 3;
      else if (taken)     e_pcsel[i] = 1;
      else                e_pcsel[i] = 0;
      e_vx[i]     = !nop && !stl && (instr_X != NOP_WORD);
      e_regwen[i] = e_vx[i] && op != OP_BR && op != OP_ST;
      e_memrw[i]  = e_vx[i] && op == OP_ST;
      e_brun[i]   = (op == OP_BR) && (f3 == 3'd6 || f3 == 3'd7);
    end
  endtask

  task automatic model_commit();
    logic [6:0] op;
    op = instr_X[6:0];
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 3; k >= 2; k--) begin
          h_valid[i][k] = h_valid[i][k-1]; h_wen[i][k] = h_wen[i][k-1];
          h_load[i][k]  = h_load[i][k-1];  h_rd[i][k]  = h_rd[i][k-1];
        end
        h_valid[i][1] = e_vx[i];
        h_rd[i][1]    = instr_X[11:7];
        h_wen[i][1]   = (op != OP_BR && op != OP_ST);
        h_load[i][1]  = (op == OP_LOAD);
        kill_q[i]     = (e_pcsel[i] == 1);
        if (hold_left[i] > 0) hold_left[i]--;
      end
    end
  endtask

  always @(posedge clk) model_commit();

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      // Forward selects are don't-care while stalled.
      if (!e_stall[i]) begin
        check($sformatf("fw_RS1[%0d]", i), 32'(o_fw1[i]), 32'(e_fw1[i]));
        check($sformatf("fw_RS2[%0d]", i), 32'(o_fw2[i]), 32'(e_fw2[i]));
      end
      check($sformatf("stall[%0d]", i),  32'(o_stall[i]),  32'(e_stall[i]));
      check($sformatf("PC_sel[%0d]", i), 32'(o_pcsel[i]),  32'(e_pcsel[i]));
      check($sformatf("NOP[%0d]", i),    32'(o_nop[i]),    32'(e_nop[i]));
      check($sformatf("RegWEn[%0d]", i), 32'(o_regwen[i]), 32'(e_regwen[i]));
      check($sformatf("MemRW[%0d]", i),  32'(o_memrw[i]),  32'(e_memrw[i]));
      check($sformatf("BrUn[%0d]", i),   32'(o_brun[i]),   32'(e_brun[i]));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [2:0] brf [6];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] hi;
    int pick;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_ST, OP_I, OP_R};
    brf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    pick = $urandom_range(0, 10);
    if (pick >= 9) return NOP_WORD;
    op = ops[pick];
    f3 = (op == OP_BR) ? brf[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
    hi = 7'($urandom());
    return {hi, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
            5'($urandom_range(0, 7)), op};
  endfunction

  task automatic step(input logic r, input logic [31:0] ins, input logic eq, input logic lt);
    @(negedge clk);
    rst_n = r; instr_X = ins; BrEq = eq; BrLT = lt;
    if (!r) model_clear();
    #1;
    model_eval();
    compare_all();
  endtask

  logic [31:0] add_x5, add_x6_x5, lw_x7, add_x8_x7, addi_x10, jal_x1;

  initial begin
    rst_n = 1'b0; instr_X = NOP_WORD; BrEq = 1'b0; BrLT = 1'b0;
    add_x5    = enc(OP_R, 5'd5, 3'd0, 5'd1, 5'd2);
    add_x6_x5 = enc(OP_R, 5'd6, 3'd0, 5'd5, 5'd5);
    lw_x7     = enc(OP_LOAD, 5'd7, 3'd2, 5'd2, 5'd0);
    add_x8_x7 = enc(OP_R, 5'd8, 3'd0, 5'd7, 5'd1);
    addi_x10  = enc(OP_I, 5'd10, 3'd0, 5'd1, 5'd1);
    jal_x1    = enc(OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0);

    // Reset held 3 cycles, then 2 hold cycles, then normal fetch.
    for (int n = 0; n < 3; n++) begin
      step(1'b0, NOP_WORD, 1'b0, 1'b0);
      check("rst_pcsel", 32'(pcsel_a), 32'd2);
      check("rst_nop", 32'(nop_a), 32'd1);
    end
    for (int n = 0; n < 2; n++) begin
      step(1'b1, NOP_WORD, 1'b0, 1'b0);
      check("hold_pcsel", 32'(pcsel_a), 32'd2);
    end
    step(1'b1, NOP_WORD, 1'b0, 1'b0);
    check("run_pcsel", 32'(pcsel_a), 32'd0);
    check("run_nop", 32'(nop_a), 32'd0);

    // Back-to-back dependency forwards from M.
    step(1'b1, add_x5, 1'b0, 1'b0);
    step(1'b1, add_x6_x5, 1'b0, 1'b0);
    check("fw_m_rs1", 32'(fw1_a), 32'd1);
    check("fw_m_rs2", 32'(fw2_a), 32'd1);
    check("fw_m_rs1_d1", 32'(fw1_b), 32'd1);

    // One filler: W forwards; the one-stage build falls back to regfile.
    step(1'b1, add_x5, 1'b0, 1'b0);
    step(1'b1, NOP_WORD, 1'b0, 1'b0);
    step(1'b1, add_x6_x5, 1'b0, 1'b0);
    check("fw_w_rs1", 32'(fw1_a), 32'd2);
    check("fw_w_rs2", 32'(fw2_a), 32'd2);
    check("fw_w_d1", 32'(fw1_b), 32'd0);

    // x0 never forwards.
    step(1'b1, enc(OP_R, 5'd0, 3'd0, 5'd1, 5'd2), 1'b0, 1'b0);
    step(1'b1, enc(OP_R, 5'd9, 3'd0, 5'd0, 5'd0), 1'b0, 1'b0);
    check("fw_x0", 32'(fw1_a), 32'd0);

    // Load-use: one stall cycle, then forward from W.
    step(1'b1, lw_x7, 1'b0, 1'b0);
    step(1'b1, add_x8_x7, 1'b0, 1'b0);
    check("lu_stall", 32'(stall_a), 32'd1);
    check("lu_pcsel", 32'(pcsel_a), 32'd3);
    check("lu_regwen", 32'(regwen_a), 32'd0);
    step(1'b1, add_x8_x7, 1'b0, 1'b0);
    check("lu_release", 32'(stall_a), 32'd0);
    check("lu_fw_w", 32'(fw1_a), 32'd2);

    // Taken BEQ kills the next slot, which never becomes a forward source.
    step(1'b1, enc(OP_BR, 5'd0, 3'd0, 5'd1, 5'd2), 1'b1, 1'b0);
    check("beq_taken", 32'(pcsel_a), 32'd1);
    step(1'b1, addi_x10, 1'b0, 1'b0);
    check("kill_nop", 32'(nop_a), 32'd1);
    check("kill_regwen", 32'(regwen_a), 32'd0);
    step(1'b1, enc(OP_R, 5'd11, 3'd0, 5'd10, 5'd10), 1'b0, 1'b0);
    check("kill_no_fwd", 32'(fw1_a), 32'd0);
    step(1'b1, enc(OP_BR, 5'd0, 3'd1, 5'd1, 5'd2), 1'b1, 1'b0);
    check("bne_not_taken", 32'(pcsel_a), 32'd0);

    // JAL then wrong-path JAL.
    step(1'b1, jal_x1, 1'b0, 1'b0);
    check("jal_taken", 32'(pcsel_a), 32'd1);
    step(1'b1, jal_x1, 1'b0, 1'b0);
    check("jal2_nop", 32'(nop_a), 32'd1);
    check("jal2_pcsel", 32'(pcsel_a), 32'd0);
    step(1'b1, addi_x10, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stall.
    step(1'b1, lw_x7, 1'b0, 1'b0);
    step(1'b1, add_x8_x7, 1'b0, 1'b0);
    check("pre_rst_stall", 32'(stall_b), 32'd1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    model_eval();
    compare_all();
    check("async_stall", 32'(stall_b), 32'd0);
    check("async_pcsel", 32'(pcsel_b), 32'd2);
    check("async_fw", 32'(fw1_a), 32'd0);
    step(1'b1, NOP_WORD, 1'b0, 1'b0);
    check("rehold_pcsel", 32'(pcsel_a), 32'd2);
    step(1'b1, NOP_WORD, 1'b0, 1'b0);

    // Random traffic with rare reset pulses.
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 99) != 0), rand_instr(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
